ulpi_phy_model: RTL and testbench

Synthesizable PHY-side ULPI responder: the opposite end of the link-side ULPI block. It owns DIR and NXT, decodes TX CMDs from the link, and services register writes, reads and transmit packets. It injects RX CMDs and receive packets on request. It is the link's bench partner and a loopback target on the audio card FPGA, with bus tri-stating done in the top-level wrapper.

---
 rtl/ulpi_pkg.sv | 38 +++
 rtl/ulpi_phy_regfile.sv | 36 +++
 rtl/ulpi_phy_model.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ulpi_phy_model.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// ulpi_pkg
// Constants and types shared by the PHY-side responder and the link-side block.
//   CMD_*          : TX CMD codes carried in DATA[7:6] of the link's command byte
//   REG_COUNT      : depth of the ULPI register file
//   ULPI_EXT_ADDR  : extended-register address (handled as a plain address here)
//   ulpi_state_e   : PHY responder FSM states
//   cmd_code()     : extracts the command code from a bus byte
package ulpi_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;

  localparam int REG_COUNT = 64;
  localparam int REG_ADDR_W = 6;
  localparam logic [REG_ADDR_W-1:0] ULPI_EXT_ADDR = 6'h2F;

  typedef enum logic [3:0] {
    IDLE,
    REGW_ACK,
    REGW_DATA,
    REGW_STP,
    REGR_ACK,
    REGR_TURN,
    REGR_DATA,
    TX,
    TURN_IN,
    RXCMD,
    RX_PKT,
    TURN_OUT
  } ulpi_state_e;

  function automatic logic [1:0] cmd_code(input logic [7:0] bus_byte);
    return bus_byte[7:6];
  endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// ulpi_phy_regfile
// 64 x 8 ULPI register file: one synchronous write port, one combinational
// read port, whole array cleared by synchronous reset.
//   clk      : clock
//   srst     : synchronous active-high clear
//   wr_en    : write strobe, wr_addr/wr_data written at the clock edge
//   rd_addr  : read address; rd_data follows it combinationally
module ulpi_phy_regfile
  import ulpi_pkg::*;
(
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  // Held in flops rather than block RAM: the whole array must clear in one
  // cycle and the read path is asynchronous.
  logic [7:0] mem_reg [REG_COUNT];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/ulpi_phy_model.sv
// ulpi_phy_model
// PHY-side ULPI responder. Owns DIR/NXT, decodes link TX CMDs, services
// register writes/reads and transmit packets, and injects RX CMDs and
// receive packets on request. Tri-stating happens in the wrapper.
// Ports:
//   clk_60m, rst            : ULPI clock, synchronous active-high reset
//   link_resetn             : link USB_RESETN; low acts exactly like rst
//   data_i / data_o/data_oe : bus from link / bus to link + drive enable
//   dir, nxt, stp           : ULPI control
//   rxcmd_i/_req/_ack       : stand-alone RX CMD injection
//   rx_data/valid/last/ready: receive packet source (valid/ready handshake)
//   tx_cmd, tx_data/strb/end: captured transmit command and payload
//   reg_wr_strb/addr/data   : completed register write notification
//   proto_err               : one-cycle pulse on link protocol violation
// Parameter:
//   TX_NXT_PERIOD           : NXT drops for one cycle after every N payload
//                             bytes accepted in transmit; 0 disables
module ulpi_phy_model
  import ulpi_pkg::*;
#(
  parameter int unsigned TX_NXT_PERIOD = 0
) (
  input  logic       clk_60m,
  input  logic       rst,
  input  logic       link_resetn,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       dir,
  output logic       nxt,
  input  logic       stp,
  input  logic [7:0] rxcmd_i,
  input  logic       rxcmd_req,
  output logic       rxcmd_ack,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic       rx_ready,
  output logic [5:0] tx_cmd,
  output logic [7:0] tx_data,
  output logic       tx_strb,
  output logic       tx_end,
  output logic       reg_wr_strb,
  output logic [5:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       proto_err
);

  localparam logic [7:0] TX_CNT_LAST = 8'(TX_NXT_PERIOD - 1);

  logic        srst;
  ulpi_state_e state_reg, state_next;

  logic [5:0]  addr_reg;
  logic        rx_pkt_reg;      // RX entry was for a packet, not a lone RX CMD
  logic        tx_first_reg;    // next accepted TX byte is the command byte
  logic        throttle_reg;    // forces one NXT-low cycle in TX
  logic [7:0]  tx_cnt_reg;

  logic [5:0]  tx_cmd_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_strb_reg;
  logic        tx_end_reg;
  logic        reg_wr_strb_reg;
  logic [5:0]  reg_wr_addr_reg;
  logic [7:0]  reg_wr_data_reg;
  logic        proto_err_reg;

  logic        proto_err_next;
  logic        regw_en;
  logic        tx_accept;
  logic [7:0]  rd_data;

  // Link-held reset behaves identically to the block reset.
  assign srst = rst | ~link_resetn;

  assign regw_en   = (state_reg == REGW_DATA);
  assign tx_accept = (state_reg == TX) && nxt && !stp;

  ulpi_phy_regfile u_regfile (
    .clk     (clk_60m),
    .srst    (srst),
    .wr_en   (regw_en),
    .wr_addr (addr_reg),
    .wr_data (data_i),
    .rd_addr (addr_reg),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_60m) begin
    if (srst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next     = state_reg;
    proto_err_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (stp) begin
          proto_err_next = 1'b1;
        end else if (rxcmd_req || rx_valid) begin
          // PHY traffic wins; any command on the bus is dropped (link abort).
          state_next = TURN_IN;
        end else begin
          case (cmd_code(data_i))
            CMD_IDLE: state_next = IDLE;
            CMD_TX:   state_next = TX;
            CMD_REGW: state_next = REGW_ACK;
            CMD_REGR: state_next = REGR_ACK;
            default:  state_next = IDLE;
          endcase
        end
      end
      REGW_ACK:  state_next = REGW_DATA;
      REGW_DATA: state_next = REGW_STP;
      REGW_STP: begin
        proto_err_next = !stp;
        state_next     = IDLE;
      end
      REGR_ACK:  state_next = REGR_TURN;
      REGR_TURN: state_next = REGR_DATA;
      REGR_DATA: state_next = TURN_OUT;
      TX: begin
        if (stp) begin
          state_next = IDLE;
        end
      end
      TURN_IN:   state_next = RXCMD;
      RXCMD:     state_next = rx_pkt_reg ? RX_PKT : TURN_OUT;
      RX_PKT: begin
        if (rx_valid && rx_last) begin
          state_next = TURN_OUT;
        end
      end
      TURN_OUT: begin
        // The link must not drive the bus during the turnaround after DIR falls.
        proto_err_next = (data_i != 8'h00);
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- bus outputs
  always_comb begin
    dir       = 1'b0;
    nxt       = 1'b0;
    data_oe   = 1'b0;
    data_o    = 8'h00;
    rxcmd_ack = 1'b0;
    rx_ready  = 1'b0;
    unique case (state_reg)
      REGW_ACK, REGW_DATA, REGR_ACK: begin
        nxt = 1'b1;
      end
      REGR_TURN, TURN_IN: begin
        dir = 1'b1;
      end
      REGR_DATA: begin
        dir     = 1'b1;
        data_oe = 1'b1;
        data_o  = rd_data;
      end
      TX: begin
        nxt = !throttle_reg;
      end
      RXCMD: begin
        dir       = 1'b1;
        data_oe   = 1'b1;
        data_o    = rxcmd_i;
        rxcmd_ack = 1'b1;
      end
      RX_PKT: begin
        dir     = 1'b1;
        data_oe = 1'b1;
        if (rx_valid) begin
          data_o   = rx_data;
          nxt      = 1'b1;
          rx_ready = 1'b1;
        end else begin
          // Source starved: fill the gap with an RX CMD (NXT low).
          data_o    = rxcmd_i;
          rxcmd_ack = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_60m) begin
    if (srst) begin
      addr_reg        <= '0;
      rx_pkt_reg      <= 1'b0;
      tx_first_reg    <= 1'b0;
      throttle_reg    <= 1'b0;
      tx_cnt_reg      <= '0;
      tx_cmd_reg      <= '0;
      tx_data_reg     <= '0;
      tx_strb_reg     <= 1'b0;
      tx_end_reg      <= 1'b0;
      reg_wr_strb_reg <= 1'b0;
      reg_wr_addr_reg <= '0;
      reg_wr_data_reg <= '0;
      proto_err_reg   <= 1'b0;
    end else begin
      tx_strb_reg     <= 1'b0;
      tx_end_reg      <= 1'b0;
      reg_wr_strb_reg <= 1'b0;
      proto_err_reg   <= proto_err_next;

      // In IDLE, keep per-transaction context primed; the final IDLE edge
      // is the one that sampled the command.
      if (state_reg == IDLE) begin
        addr_reg     <= data_i[5:0];
        rx_pkt_reg   <= rx_valid;
        tx_first_reg <= 1'b1;
        throttle_reg <= 1'b0;
        tx_cnt_reg   <= '0;
      end

      if (regw_en) begin
        reg_wr_strb_reg <= 1'b1;
        reg_wr_addr_reg <= addr_reg;
        reg_wr_data_reg <= data_i;
      end

      if (state_reg == TX) begin
        if (stp) begin
          tx_end_reg <= 1'b1;
        end else if (tx_accept) begin
          if (tx_first_reg) begin
            tx_cmd_reg   <= data_i[5:0];
            tx_first_reg <= 1'b0;
            tx_cnt_reg   <= '0;
          end else begin
            tx_strb_reg <= 1'b1;
            tx_data_reg <= data_i;
            if (TX_NXT_PERIOD != 0) begin
              if (tx_cnt_reg == TX_CNT_LAST) begin
                tx_cnt_reg   <= '0;
                throttle_reg <= 1'b1;
              end else begin
                tx_cnt_reg <= tx_cnt_reg + 8'd1;
              end
            end
          end
        end else begin
          // The NXT-low cycle has elapsed.
          throttle_reg <= 1'b0;
        end
      end
    end
  end

  assign tx_cmd      = tx_cmd_reg;
  assign tx_data     = tx_data_reg;
  assign tx_strb     = tx_strb_reg;
  assign tx_end      = tx_end_reg;
  assign reg_wr_strb = reg_wr_strb_reg;
  assign reg_wr_addr = reg_wr_addr_reg;
  assign reg_wr_data = reg_wr_data_reg;
  assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_ulpi_phy_model.sv
// Directed bench for ulpi_phy_model (TX_NXT_PERIOD = 2). The bench plays the
// link side of the bus and the PHY's RX data source.
module tb_ulpi_phy_model;
  import ulpi_pkg::*;

  logic       clk_60m = 1'b0;
  logic       rst, link_resetn;
  logic [7:0] data_i, data_o, rxcmd_i, rx_data, tx_data, reg_wr_data;
  logic       data_oe, dir, nxt, stp, rxcmd_req, rxcmd_ack;
  logic       rx_valid, rx_last, rx_ready, tx_strb, tx_end, reg_wr_strb, proto_err;
  logic [5:0] tx_cmd, reg_wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_60m = ~clk_60m;

  ulpi_phy_model #(.TX_NXT_PERIOD(2)) dut (
    .clk_60m(clk_60m), .rst(rst), .link_resetn(link_resetn),
    .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
    .dir(dir), .nxt(nxt), .stp(stp),
    .rxcmd_i(rxcmd_i), .rxcmd_req(rxcmd_req), .rxcmd_ack(rxcmd_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .tx_cmd(tx_cmd), .tx_data(tx_data), .tx_strb(tx_strb), .tx_end(tx_end),
    .reg_wr_strb(reg_wr_strb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_60m);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dir"}, dir, 0);
    check({tag, " nxt"}, nxt, 0);
    check({tag, " data_oe"}, data_oe, 0);
    check({tag, " data_o"}, data_o, 0);
    check({tag, " rxcmd_ack"}, rxcmd_ack, 0);
    check({tag, " rx_ready"}, rx_ready, 0);
    check({tag, " tx_cmd"}, tx_cmd, 0);
    check({tag, " tx_data"}, tx_data, 0);
    check({tag, " tx_strb"}, tx_strb, 0);
    check({tag, " tx_end"}, tx_end, 0);
    check({tag, " reg_wr_strb"}, reg_wr_strb, 0);
    check({tag, " reg_wr_addr"}, reg_wr_addr, 0);
    check({tag, " reg_wr_data"}, reg_wr_data, 0);
    check({tag, " proto_err"}, proto_err, 0);
  endtask

  // Command at edge k, data at k+2, STP (optional) at k+3.
  task automatic reg_write(input logic [5:0] addr, input logic [7:0] val, input bit with_stp);
    data_i = {CMD_REGW, addr};
    tick;
    check("regw nxt k", nxt, 1);
    check("regw dir k", dir, 0);
    tick;
    check("regw nxt k+1", nxt, 1);
    data_i = val;
    tick;
    check("regw nxt k+2", nxt, 0);
    check("regw strb", reg_wr_strb, 1);
    check("regw addr", reg_wr_addr, addr);
    check("regw data", reg_wr_data, val);
    data_i = 8'h00;
    stp    = with_stp;
    tick;
    stp = 1'b0;
    check("regw strb after", reg_wr_strb, 0);
    check("regw proto_err", proto_err, with_stp ? 0 : 1);
    check("regw idle nxt", nxt, 0);
    $display("reg write addr=%02h data=%02h stp=%0d", addr, val, with_stp);
  endtask

  // Command at edge k: NXT k, DIR k+1, data k+2, DIR low k+3, IDLE k+4.
  task automatic reg_read(input logic [5:0] addr, input logic [7:0] exp, input logic [7:0] turn_val);
    data_i = {CMD_REGR, addr};
    tick;
    check("regr nxt k", nxt, 1);
    check("regr dir k", dir, 0);
    data_i = 8'h00;
    tick;
    check("regr dir k+1", dir, 1);
    check("regr oe k+1", data_oe, 0);
    check("regr nxt k+1", nxt, 0);
    tick;
    check("regr oe k+2", data_oe, 1);
    check("regr data k+2", data_o, exp);
    check("regr dir k+2", dir, 1);
    tick;
    check("regr dir k+3", dir, 0);
    check("regr oe k+3", data_oe, 0);
    data_i = turn_val;
    tick;
    data_i = 8'h00;
    check("regr turn proto_err", proto_err, (turn_val != 8'h00) ? 1 : 0);
    $display("reg read addr=%02h expect=%02h turn=%02h", addr, exp, turn_val);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] tx_bytes [7];
    logic [8:0] exp_nxt_v;
    int tx_idx, strb_cnt, dir_cycles, strb_seen, rx_bytes;

    rst = 1'b1; link_resetn = 1'b1; data_i = 8'h00; stp = 1'b0;
    rxcmd_i = 8'h00; rxcmd_req = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0;
    tick;
    tick;
    check_reset_outputs("reset");
    $display("reset applied");
    rst = 1'b0;
    tick;

    // Register write / read-back, preload and read, cleared entry, extended address.
    reg_write(6'h07, 8'h07, 1'b1);
    reg_read(6'h07, 8'h07, 8'h00);
    reg_write(6'h09, 8'h5A, 1'b1);
    reg_read(6'h09, 8'h5A, 8'h00);
    reg_read(6'h03, 8'h00, 8'h00);
    reg_write(ULPI_EXT_ADDR, 8'hE1, 1'b1);
    reg_read(ULPI_EXT_ADDR, 8'hE1, 8'h00);

    // RX packet 01..05, source gap before byte 03.
    rxcmd_i = 8'h4C; rx_data = 8'h01; rx_valid = 1'b1; rx_last = 1'b0;
    tick;
    check("rx turn dir", dir, 1);
    check("rx turn oe", data_oe, 0);
    check("rx turn ready", rx_ready, 0);
    tick;
    check("rx cmd data", data_o, 8'h4C);
    check("rx cmd nxt", nxt, 0);
    check("rx cmd ack", rxcmd_ack, 1);
    check("rx cmd ready", rx_ready, 0);
    tick;
    rx_bytes = 0;
    for (int b = 1; b <= 5; b++) begin
      if (b == 3) begin
        rx_valid = 1'b0;
        #1;
        check("rx gap data", data_o, 8'h4C);
        check("rx gap nxt", nxt, 0);
        check("rx gap ready", rx_ready, 0);
        tick;
      end
      rx_valid = 1'b1;
      rx_data  = 8'(b);
      rx_last  = (b == 5);
      #1;
      check("rx byte data", data_o, 8'(b));
      check("rx byte nxt", nxt, 1);
      check("rx byte ready", rx_ready, 1);
      if (nxt && rx_ready) rx_bytes++;
      tick;
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    check("rx byte count", rx_bytes, 5);
    check("rx exit dir", dir, 0);
    check("rx exit oe", data_oe, 0);
    tick;
    check("rx exit proto_err", proto_err, 0);
    $display("rx packet rxcmd=4c bytes=%0d", rx_bytes);

    // Transmit 43 + 6 payload bytes, NXT low after every 2 payload bytes.
    tx_bytes  = '{8'h43, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    exp_nxt_v = 9'b110110111;  // cycle 0 in bit 0
    tx_idx = 0; strb_cnt = 0;
    data_i = tx_bytes[0];
    tick;
    for (int c = 0; c < 9; c++) begin
      check("tx nxt", nxt, exp_nxt_v[c]);
      tick;
      if (exp_nxt_v[c]) begin
        if (tx_idx == 0) begin
          check("tx cmd", tx_cmd, 6'h03);
          check("tx cmd no strb", tx_strb, 0);
        end else begin
          check("tx strb", tx_strb, 1);
          check("tx data", tx_data, tx_bytes[tx_idx]);
        end
        tx_idx++;
      end else begin
        check("tx throttle strb", tx_strb, 0);
      end
      if (tx_strb) strb_cnt++;
      data_i = (tx_idx < 7) ? tx_bytes[tx_idx] : 8'h00;
    end
    check("tx strb count", strb_cnt, 6);
    stp = 1'b1;
    check("tx nxt before stp", nxt, 0);
    tick;
    stp = 1'b0;
    check("tx end", tx_end, 1);
    check("tx end no strb", tx_strb, 0);
    tick;
    check("tx end pulse", tx_end, 0);
    check("tx idle nxt", nxt, 0);
    $display("transmit cmd=43 payload=%0d", strb_cnt);

    // PHY request beats a register write command on the bus.
    rxcmd_i = 8'h2E; data_i = 8'h88; rxcmd_req = 1'b1;
    dir_cycles = 0; strb_seen = 0;
    tick;
    check("abort dir wins", dir, 1);
    check("abort nxt", nxt, 0);
    data_i = 8'h00; rxcmd_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (dir) dir_cycles++;
      if (reg_wr_strb) strb_seen++;
      if (c == 1) begin
        check("abort rxcmd data", data_o, 8'h2E);
        check("abort rxcmd ack", rxcmd_ack, 1);
      end
      tick;
    end
    check("rxcmd dir cycles", dir_cycles, 2);
    check("abort no write strb", strb_seen, 0);
    $display("abort rxcmd=2e over cmd=88");
    reg_read(6'h08, 8'h00, 8'h00);

    // Protocol errors: STP in IDLE, missing STP, bus driven in TURN_OUT.
    stp = 1'b1;
    tick;
    stp = 1'b0;
    check("idle stp proto_err", proto_err, 1);
    check("idle stp dir", dir, 0);
    check("idle stp nxt", nxt, 0);
    tick;
    check("idle stp pulse", proto_err, 0);
    $display("error stp in idle");
    reg_write(6'h04, 8'h44, 1'b0);
    reg_read(6'h04, 8'h44, 8'h3C);

    // Reset while in REGW_DATA; the regfile is cleared, never written with CC.
    data_i = {CMD_REGW, 6'h15};
    tick;
    tick;
    data_i = 8'hCC; rst = 1'b1;
    tick;
    check_reset_outputs("mid-write reset");
    rst = 1'b0; data_i = 8'h00;
    tick;
    $display("reset during register write");
    reg_read(6'h15, 8'h00, 8'h00);
    reg_read(6'h07, 8'h00, 8'h00);

    // Link reset behaves as block reset.
    reg_write(6'h21, 8'h77, 1'b1);
    link_resetn = 1'b0;
    tick;
    check_reset_outputs("link reset");
    link_resetn = 1'b1;
    tick;
    $display("link reset pulse");
    reg_read(6'h21, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
